// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: sizes, mem_op fields,
// FSM states and the MEM latch layout {valid,result,wr_reg,wregno,misalign,timeout}.
package mem_access_stage_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    localparam int OP_IS_MEM   = 3;
    localparam int OP_IS_STORE = 2;
    localparam int OP_SIZE_HI  = 1;
    localparam int OP_SIZE_LO  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // valid + result + wr_reg + wregno + misalign + timeout
    function automatic int mem_latch_w(input int dbits, input int rbits);
        return dbits + rbits + 4;
    endfunction

    // Size 3 is not a legal encoding; it is treated like a word.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        unique case (1'b1)
            size == MEM_B: m = 1'b0;
            size == MEM_H: m = a[0];
            default:       m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and sign/zero extension (purely combinational).
// Ports: rdata, addr_lo, size, is_unsigned -> result.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [DBITS-1:0] rdata,
    input  logic [1:0]       addr_lo,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    output logic [DBITS-1:0] result
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sb;
    logic        sh;

    always_comb begin
        b = rdata[7:0];
        unique case (addr_lo)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sb = ~is_unsigned & b[7];
        sh = ~is_unsigned & h[15];
        result = rdata;
        unique case (1'b1)
            size == MEM_B: result = {{(DBITS-8){sb}}, b};
            size == MEM_H: result = {{(DBITS-16){sh}}, h};
            default:       result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: byte/half/word loads and stores over a req/ack port,
// registered MEM latch to writeback, hazard info to decode.
// Ports: in_* from execute latch, dmem_* memory port, out_* MEM latch,
// fwd_* to decode. Optional watchdog enabled by define MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DBITS          = 32,
    parameter int REGNOBITS      = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_mem_op,
    input  logic                 in_unsigned,
    input  logic [DBITS-1:0]     in_aluout,
    input  logic [DBITS-1:0]     in_store_data,
    input  logic                 in_wr_reg,
    input  logic [REGNOBITS-1:0] in_wregno,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DBITS-1:0]     dmem_addr,
    output logic [DBITS-1:0]     dmem_wdata,
    output logic [3:0]           dmem_wstrb,
    input  logic                 dmem_ack,
    input  logic [DBITS-1:0]     dmem_rdata,
    output logic                 out_valid,
    output logic [DBITS-1:0]     out_result,
    output logic                 out_wr_reg,
    output logic [REGNOBITS-1:0] out_wregno,
    output logic                 out_misalign,
    output logic                 out_timeout,
    output logic                 fwd_busy,
    output logic [REGNOBITS-1:0] fwd_wregno
);

    localparam int LW = mem_latch_w(DBITS, REGNOBITS);

    mem_state_e state;
    mem_state_e state_nx;

    logic [LW-1:0] latch;
    logic [LW-1:0] latch_nx;

    logic                 cap_store;
    logic                 cap_wr;
    logic                 cap_uns;
    logic [1:0]           cap_size;
    logic [DBITS-1:0]     cap_addr;
    logic [DBITS-1:0]     cap_wdata;
    logic [3:0]           cap_wstrb;
    logic [REGNOBITS-1:0] cap_wregno;

    logic             in_mem;
    logic             in_store;
    logic [1:0]       in_size;
    logic             mis;
    logic             start;
    logic             busy;
    logic             abort;
    logic             ld_wr;
    logic [DBITS-1:0] st_wdata;
    logic [3:0]       st_wstrb;
    logic [DBITS-1:0] ld_result;

    assign in_mem   = in_mem_op[OP_IS_MEM];
    assign in_store = in_mem_op[OP_IS_STORE];
    assign in_size  = in_mem_op[OP_SIZE_HI:OP_SIZE_LO];
    assign mis      = misaligned(in_size, in_aluout[1:0]);
    assign busy     = (state == ST_BUSY);
    assign start    = !busy && in_valid && in_mem && !mis;

    always_comb begin
        st_wdata = in_store_data;
        st_wstrb = 4'b1111;
        unique case (1'b1)
            in_size == MEM_B: begin
                st_wdata = DBITS'({4{in_store_data[7:0]}});
                st_wstrb = 4'b0001 << in_aluout[1:0];
            end
            in_size == MEM_H: begin
                st_wdata = DBITS'({2{in_store_data[15:0]}});
                st_wstrb = in_aluout[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = in_store_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    mem_access_stage_load_align #(
        .DBITS(DBITS)
    ) u_align (
        .rdata      (dmem_rdata),
        .addr_lo    (cap_addr[1:0]),
        .size       (cap_size),
        .is_unsigned(cap_uns),
        .result     (ld_result)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CB = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = (CB > 8) ? CB : 8;

    logic [CW-1:0] tmo_cnt;

    // Held at zero outside BUSY, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (!busy) begin
            tmo_cnt <= '0;
        end else if (!dmem_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Counter equals BUSY cycles already spent; abort in the limit cycle.
    assign abort = busy && !dmem_ack &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    assign ld_wr = !cap_store && cap_wr && (cap_wregno != '0);

    always_comb begin
        state_nx = state;
        latch_nx = '0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!in_mem) begin
                        latch_nx = {1'b1, in_aluout,
                                    in_wr_reg && (in_wregno != '0),
                                    in_wregno, 2'b00};
                    end else if (mis) begin
                        latch_nx = {1'b1, in_aluout, 1'b0,
                                    in_wregno, 2'b10};
                    end else begin
                        state_nx = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    state_nx = ST_IDLE;
                    latch_nx = {1'b1,
                                cap_store ? cap_addr : ld_result,
                                ld_wr, cap_wregno, 2'b00};
                end else if (abort) begin
                    state_nx = ST_IDLE;
                    latch_nx = {1'b1, cap_addr, 1'b0,
                                cap_wregno, 2'b01};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            latch <= '0;
        end else begin
            state <= state_nx;
            latch <= latch_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_store  <= 1'b0;
            cap_wr     <= 1'b0;
            cap_uns    <= 1'b0;
            cap_size   <= MEM_B;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            cap_wregno <= '0;
        end else if (start) begin
            cap_store  <= in_store;
            cap_wr     <= in_wr_reg;
            cap_uns    <= in_unsigned;
            cap_size   <= in_size;
            cap_addr   <= in_aluout;
            cap_wdata  <= st_wdata;
            cap_wstrb  <= st_wstrb & {4{in_store}};
            cap_wregno <= in_wregno;
        end
    end

    assign in_ready   = !busy;
    assign dmem_req   = busy;
    assign dmem_we    = busy && cap_store;
    assign dmem_addr  = {cap_addr[DBITS-1:2], 2'b00};
    assign dmem_wdata = cap_wdata;
    assign dmem_wstrb = busy ? cap_wstrb : 4'b0000;

    assign {out_valid, out_result, out_wr_reg,
            out_wregno, out_misalign, out_timeout} = latch;

    assign fwd_busy   = busy && !cap_store && cap_wr;
    assign fwd_wregno = busy ? cap_wregno : out_wregno;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the address-generate/execute stage.
- Consumes the registered execute-stage result:
  - ALU result or effective address.
  - Store data.
  - Destination register info.
- Performs byte/half/word loads and stores over a req/ack data-memory port and stalls upstream while an access is outstanding.
- Registers the result into the MEM latch feeding writeback, and exports destination info to decode for hazard/forwarding.

Parameters:
- DBITS, 32, data/address width.
- REGNOBITS, 5, register-number width.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute latch holds a valid instruction
- in_ready  out  1  stage can accept; upstream holds its latch when 0
- in_mem_op  in  4  {is_mem, is_store, size[1:0]}; size 0=B, 1=H, 2=W
- in_unsigned  in  1  zero-extend loads (LBU/LHU)
- in_aluout  in  DBITS  ALU result / effective address
- in_store_data  in  DBITS  store value (rs2)
- in_wr_reg  in  1  instruction writes a register
- in_wregno  in  REGNOBITS  destination register
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  write request
- dmem_addr  out  DBITS  word-aligned address
- dmem_wdata  out  DBITS  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  access complete; rdata valid this cycle for reads
- dmem_rdata  in  DBITS  read word
- out_valid  out  1  MEM latch valid
- out_result  out  DBITS  load data or ALU passthrough
- out_wr_reg  out  1  writeback enable
- out_wregno  out  REGNOBITS  writeback register
- out_misalign  out  1  misaligned access flagged
- out_timeout  out  1  watchdog abort flagged
- fwd_busy  out  1  load outstanding; decode must stall on matching register
- fwd_wregno  out  REGNOBITS  register of the outstanding access, or the latched instruction

Behaviour:
- Reset:
  - State IDLE.
  - All out_* = 0, dmem_req = 0, dmem_we = 0, dmem_wstrb = 0, fwd_busy = 0.
- States: IDLE, BUSY.
- in_ready = (state == IDLE). An instruction is accepted when in_valid && in_ready.
- IDLE, non-memory op accepted:
  - Next cycle: out_valid = 1, out_result = in_aluout, wr/wregno copied.
  - Latency 1, one instruction per cycle.
- IDLE, accepted with in_valid = 0: out_valid = 0 next cycle (bubble).
- Misaligned access (H with addr[0] = 1; W with addr[1:0] != 0):
  - No memory request.
  - Next cycle: out_valid = 1, out_misalign = 1, out_wr_reg = 0, out_result = in_aluout.
- Aligned memory op accepted:
  - Capture op, address, data and register into internal regs; go to BUSY.
  - out_valid = 0 in every BUSY cycle.
- BUSY:
  - dmem_req = 1; address, we, wdata and wstrb are stable from registers.
  - dmem_addr = {addr[DBITS-1:2], 2'b00}.
  - Stores: B replicates the byte ×4, wstrb = 1 << addr[1:0]; H replicates the half ×2, wstrb = 0011 or 1100; W uses wstrb = 1111.
  - Ack may arrive in the first BUSY cycle.
  - On dmem_ack: return to IDLE. Next cycle out_valid = 1.
  - Loads: select the lane by addr[1:0], then sign- or zero-extend per in_unsigned.
  - Stores: out_wr_reg = 0.
- Load latency: accepted at cycle N, dmem_req at N+1, earliest out_valid at N+2.
- fwd_busy = BUSY && captured op is a load && captured wr_reg.
- fwd_wregno = captured register in BUSY, otherwise out_wregno.
- dmem_ack in IDLE is ignored.
- Reset during BUSY: dmem_req drops the next cycle and any late ack is ignored.
- x0 destination: out_wr_reg is forced to 0 when wregno == 0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - An 8+-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: abort to IDLE; next cycle out_valid = 1, out_timeout = 1, out_wr_reg = 0.
  - An ack arriving in the limit cycle wins over the timeout.
- Disabled: BUSY waits indefinitely, out_timeout is tied to 0, and no counter exists.

Decomposition:
- Shared package/define header holds:
  - Size encodings MEM_B/MEM_H/MEM_W.
  - mem_op field positions.
  - State encodings.
  - MEM latch width and field order {valid, result, wr_reg, wregno, misalign, timeout}.
- Sub-module load_align: pure combinational lane-select and extend (rdata, addr[1:0], size, unsigned -> result). It is reused by any future cache path.

Test Plan:
- ADD passthrough: in_aluout = 0x1234 with wr_reg, r5 -> out_valid next cycle, out_result = 0x1234, out_wregno = 5, in_ready held at 1.
- LB at address 0x103, rdata = 0x80FF_FF00, ack on the first BUSY cycle -> dmem_addr = 0x100, out_result = 0xFFFFFF80 two cycles after accept; LBU of the same gives 0x80.
- SH at 0x102, data 0xABCD, ack delayed 3 cycles:
  - dmem_wdata = 0xABCDABCD, wstrb = 1100, in_ready = 0 for 4 cycles.
  - Then out_valid = 1 with out_wr_reg = 0.
- LW at 0x101 -> no dmem_req, out_misalign = 1, out_wr_reg = 0.
- Load to r7 pending: fwd_busy = 1 and fwd_wregno = 7 until the ack cycle. Reset asserted mid-BUSY -> all outputs 0 and a subsequent stray ack is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4: LW with no ack -> out_timeout = 1 and return to IDLE after 4 BUSY cycles.
